// File: rtl/mod_counter.sv
// Modulo-M up/down counter with sync clear, clamped parallel load, prescaled enable and
// terminal-count flags. Define MOD_COUNTER_SAT_EN to add the `sat` port (saturate instead of wrap).
module mod_counter #(
  parameter int unsigned     N = 8,
  parameter longint unsigned M = 64'd1 << N,
  parameter int unsigned     P = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
`ifdef MOD_COUNTER_SAT_EN
  input  logic         sat,
`endif
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         step,
  output logic         wrap
);

  localparam logic [N-1:0] MAX = N'(M - 64'd1);

  logic [N-1:0] r_q;
  logic         r_wrap;
  logic [N-1:0] w_load_val;
  logic         w_pdone;
  logic         w_step;
  logic         w_at_end;
  logic         w_sat;

`ifdef MOD_COUNTER_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  // With a full power-of-two modulus every load value is already in range.
  if (M < (64'd1 << N)) begin : g_clamp
    assign w_load_val = (d > MAX) ? MAX : d;
  end else begin : g_noclamp
    assign w_load_val = d;
  end

  if (P > 1) begin : g_pre
    localparam int unsigned PW = $clog2(P);
    logic [PW-1:0] r_pcnt;

    assign w_pdone = (r_pcnt == PW'(P - 1));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pcnt <= '0;
      end else if (clr || load) begin
        r_pcnt <= '0;
      end else if (en) begin
        r_pcnt <= w_pdone ? '0 : r_pcnt + PW'(1);
      end
    end
  end else begin : g_nopre
    assign w_pdone = 1'b1;
  end

  // Reset gates step so it reads 0 while the counter is held in reset.
  assign w_step   = reset & en & ~clr & ~load & w_pdone;
  assign w_at_end = up ? (r_q == MAX) : (r_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_q <= '0;
      end else if (load) begin
        r_q <= w_load_val;
      end else if (w_step) begin
        if (w_at_end) begin
          if (!w_sat) begin
            r_q    <= up ? '0 : MAX;
            r_wrap <= 1'b1;
          end
        end else begin
          r_q <= up ? r_q + N'(1) : r_q - N'(1);
        end
      end
    end
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign step     = w_step;
  assign max_tick = (r_q == MAX);
  assign min_tick = (r_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: N=4, M=10 with P=1 (dut_a) and P=3 (dut_b) driven by shared inputs,
// checked against a behavioural model through expected-value queues.
module tb_mod_counter;
  localparam int              N    = 4;
  localparam longint unsigned M    = 10;
  localparam int              MAXV = 9;
  localparam int              W    = 7;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         clr   = 1'b0;
  logic         load  = 1'b0;
  logic         en    = 1'b0;
  logic         up    = 1'b1;
  logic         sat   = 1'b0;
  logic [N-1:0] d     = '0;

  logic [N-1:0] q_a, q_b;
  logic max_a, min_a, step_a, wrap_a;
  logic max_b, min_b, step_b, wrap_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int mq_a = 0, mp_a = 0, mq_b = 0, mp_b = 0;

  always #5 clk = ~clk;

  mod_counter #(.N(N), .M(M), .P(1)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
`ifdef MOD_COUNTER_SAT_EN
    .sat(sat),
`endif
    .q(q_a), .max_tick(max_a), .min_tick(min_a), .step(step_a), .wrap(wrap_a)
  );

  mod_counter #(.N(N), .M(M), .P(3)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
`ifdef MOD_COUNTER_SAT_EN
    .sat(sat),
`endif
    .q(q_b), .max_tick(max_b), .min_tick(min_b), .step(step_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int p, inout int mq, inout int mp, output logic stp, output logic wr);
    stp = 1'b0;
    wr  = 1'b0;
    if (clr) begin
      mq = 0; mp = 0;
    end else if (load) begin
      mq = (int'(d) > MAXV) ? MAXV : int'(d);
      mp = 0;
    end else if (en) begin
      if (mp + 1 == p) begin
        mp = 0; stp = 1'b1;
      end else begin
        mp = mp + 1;
      end
    end
    if (stp) begin
      if (up) begin
        if (mq == MAXV) begin
          if (!sat) begin mq = 0; wr = 1'b1; end
        end else mq = mq + 1;
      end else begin
        if (mq == 0) begin
          if (!sat) begin mq = MAXV; wr = 1'b1; end
        end else mq = mq - 1;
      end
    end
  endtask

  function automatic logic [W-1:0] pack(input int mq, input logic wr);
    logic [N-1:0] qv;
    qv = N'(mq);
    return {qv, wr, (mq == MAXV), (mq == 0)};
  endfunction

  // Called at a falling edge: drive, check step, predict, then compare after the rising edge.
  task automatic cycle(input logic c, input logic l, input int dv, input logic e,
                       input logic u, input logic s);
    logic sa, wa, sb, wb;
    clr = c; load = l; d = N'(dv); en = e; up = u; sat = s;
    #1;
    model(1, mq_a, mp_a, sa, wa);
    model(3, mq_b, mp_b, sb, wb);
    chk("step_a", 32'(step_a), 32'(sa));
    chk("step_b", 32'(step_b), 32'(sb));
    exp_q_a.push_back(pack(mq_a, wa));
    exp_q_b.push_back(pack(mq_b, wb));
    @(posedge clk);
    #1;
    chk("out_a{q,wrap,max,min}", 32'({q_a, wrap_a, max_a, min_a}), 32'(exp_q_a.pop_front()));
    chk("out_b{q,wrap,max,min}", 32'({q_b, wrap_b, max_b, min_b}), 32'(exp_q_b.pop_front()));
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q_a"}, 32'(q_a), 0);
    chk({tag, "_q_b"}, 32'(q_b), 0);
    chk({tag, "_min_a"}, 32'(min_a), 1);
    chk({tag, "_max_a"}, 32'(max_a), 0);
    chk({tag, "_wrap_a"}, 32'(wrap_a), 0);
    chk({tag, "_wrap_b"}, 32'(wrap_b), 0);
    chk({tag, "_step_a"}, 32'(step_a), 0);
    chk({tag, "_step_b"}, 32'(step_b), 0);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; up = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_state("rst");
    end
    reset = 1'b1;

    // count up through the wrap (and the prescaled instance alongside)
    repeat (24) cycle(0, 0, 0, 1, 1, 0);

    // clamp on load, then down-wrap from 0
    cycle(0, 1, 13, 1, 1, 0);
    cycle(0, 1, 0, 1, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, 0, 0);

    // prescale with an enable gap mid-period
    cycle(1, 0, 0, 1, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 1, 0);
    repeat (6) cycle(0, 0, 0, 1, 1, 0);

    // clr beats load and step
    cycle(0, 1, 7, 1, 1, 0);
    cycle(1, 1, 5, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 1, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      cycle(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), 1'b0);
    end

    // async reset mid-count drops all state without a clock edge
    cycle(0, 1, 8, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    #2 reset = 1'b0;
    #1 chk_reset_state("arst");
    mq_a = 0; mp_a = 0; mq_b = 0; mp_b = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cycle(0, 0, 0, 1, 1, 0);

`ifdef MOD_COUNTER_SAT_EN
    cycle(0, 1, 8, 1, 1, 1);
    repeat (12) cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 1, 0, 1, 0, 1);
    repeat (8) cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
            1'b1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-M up/down counter with synchronous clear, parallel load, enable prescaler and terminal-count flags; successor to the free-running N-bit binary counter. Used as the common timing/sequencing primitive for FSM timeouts, baud/tick generation and cascaded counters in the finite-state-machine datapaths. Counts 0..M-1 in either direction, wrapping or saturating at the ends.

## Interface
- `N`, 8: counter width in bits; legal range 1..32.
- `M`, 2**N: modulus; count range 0..M-1; legal range 2..2**N.
- `P`, 1: prescale; one count step per P enabled cycles; legal range 1..65536.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- `clr` input 1: synchronous clear; highest priority.
- `load` input 1: synchronous parallel load of `d`.
- `d` input N: load value.
- `en` input 1: count enable (feeds prescaler).
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `sat` input 1: saturate mode select (present only with `MOD_COUNTER_SAT_EN`).
- `q` output N: current count.
- `max_tick` output 1: combinational, `q == M-1`.
- `min_tick` output 1: combinational, `q == 0`.
- `step` output 1: combinational, high in cycles where a count step is taken.
- `wrap` output 1: registered one-cycle pulse, high the cycle after `q` wraps (M-1→0 or 0→M-1).

## Operation
- State: count register `q` (N bits), prescale register `pcnt` (ceil(log2 P) bits, absent when P=1), `wrap` register.
- Per-cycle priority: `clr` > `load` > step > hold.
- `clr`=1: `q`←0, `pcnt`←0, `wrap`←0.
- `load`=1 (clr=0): `q`←`d` if `d` ≤ M-1, else `q`←M-1 (clamp); `pcnt`←0; `wrap`←0.
- Prescaler: when `en`=1 and neither clr nor load, `pcnt` increments; at `pcnt`=P-1, `step`=1 and `pcnt`←0. `en`=0 holds `pcnt`. P=1: `step` = `en` & ~clr & ~load.
- Step, `up`=1: `q`←`q`+1; at `q`=M-1, `q`←0 and `wrap`←1 next cycle.
- Step, `up`=0: `q`←`q`-1; at `q`=0, `q`←M-1 and `wrap`←1 next cycle.
- `wrap` is 0 in every cycle not immediately following a wrapping step.
- Arithmetic: compare against M-1 before incrementing; no intermediate value ≥ M ever appears on `q`, including M=2**N (no N+1-bit overflow relied upon).
- `max_tick`/`min_tick` derived from `q` only, independent of `en`/`up`.

## Timing
- Reset values: `q`=0, `pcnt`=0, `wrap`=0; hence `min_tick`=1, `max_tick`=0, `step`=0 during reset.
- Reset deassertion takes effect at next rising edge; first step possible on the first edge with `reset`=1.
- Latency: clr/load/step visible on `q` one cycle after the sampling edge; `wrap` coincides with the post-wrap `q` value.
- First step after enable: P enabled cycles after `pcnt`=0.
- `up` may change any cycle; applies to the step taken in that cycle only.
- Reset mid-prescale or mid-count: all state discarded, no `wrap` pulse generated.

## Configuration
- `MOD_COUNTER_SAT_EN` defined: `sat` port exists; `sat`=1 makes a step at `q`=M-1 (up) or `q`=0 (down) hold `q` and produce no `wrap`; `step` still pulses. `sat`=0 behaves as wrap mode.
- Not defined: no `sat` port; always wrap mode.

## Test plan
- Reset: N=4, M=10, P=1; hold `reset`=0 with `en`=1 → `q`=0, `min_tick`=1, `wrap`=0; release → `q` = 1,2,… on successive edges.
- Up wrap: `en`=1, `up`=1 from `q`=0 → `q` reaches 9 with `max_tick`=1, next cycle `q`=0 and `wrap`=1 for exactly one cycle.
- Down wrap and clamp: `load`=1, `d`=13 → `q`=9; `load`=1, `d`=0 then `up`=0 step → `q`=9, `wrap`=1.
- Prescale: P=3, `en`=1 continuously → `q` increments every 3rd cycle, `step` high 1 cycle in 3; `en`=0 for 2 cycles mid-period delays next step by 2 cycles.
- Priority: `clr`=1, `load`=1, `d`=5, `en`=1 same cycle at `q`=7 → `q`=0, `pcnt`=0, no `wrap`.
- Saturate (`MOD_COUNTER_SAT_EN`, `sat`=1): count up from 8 for 4 steps → `q`=9,9,9,9, `wrap` never asserted; `up`=0 from 0 → stays 0.
